truth_table_scanner: RTL
========================

TRUTH_TABLE_SCANNER -- requirements
Module: truth_table_scanner

Interface
REQ-001 The block SHALL have parameter NVARS, default 4, giving the number of function inputs scanned (legal range 1..4).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, asynchronous active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit, a request to begin a scan, sampled in IDLE only.
REQ-005 The block SHALL have port vars, output, 4 bits, the input vector driven to the function under test; bit 3 = a, bit 0 = d.
REQ-006 The block SHALL have port y_in, input, 1 bit, the function output returned from the function under test.
REQ-007 The block SHALL have port table, output, 16 bits, the captured truth table; bit i = y for input index i.
REQ-008 The block SHALL have port busy, output, 1 bit, high while a scan is in progress.
REQ-009 The block SHALL have port done, output, 1 bit, a one-cycle pulse at scan completion.

Function
REQ-010 The block SHALL implement the FSM states IDLE, DRIVE, SAMPLE and DONE.
REQ-011 In IDLE with start=1, the block SHALL on the next edge clear table, set the vector index to 0, and enter DRIVE.
REQ-012 DRIVE SHALL hold vars stable for one settle cycle and then go to SAMPLE.
REQ-013 SAMPLE SHALL write y_in into table[index].
- If index = 2^NVARS-1, the next state SHALL be DONE.
- Otherwise the index SHALL increment and the next state SHALL be DRIVE.
REQ-014 DONE SHALL assert done for exactly one cycle and then return to IDLE.
REQ-015 The index SHALL be NVARS bits wide with no wrap past 2^NVARS-1.
- Unused upper bits of vars SHALL read 0.
REQ-016 With NVARS variables, the index MSB SHALL map to vars[NVARS-1]; for example, with NVARS=3, index = {a,b,c} on vars[2:0].
REQ-017 busy SHALL be 1 in DRIVE and SAMPLE and 0 in IDLE and DONE.
REQ-018 Scan latency SHALL be 2*2^NVARS+1 cycles from the start edge to done high; for NVARS=4, done is high in cycle 33.
REQ-019 table bits at index >= 2^NVARS SHALL remain 0.
REQ-020 table SHALL hold its value after DONE until the next accepted start.
REQ-021 start asserted while busy or done is high SHALL be ignored; it SHALL NOT restart or queue a scan.
REQ-022 start held high continuously SHALL begin a new scan on the first IDLE cycle after DONE.
REQ-023 vars SHALL be 0 in IDLE.

Reset
REQ-024 While reset=1, the block SHALL force state to IDLE, index to 0, and vars, table, busy and done to 0, irrespective of clk.
REQ-025 Reset asserted mid-scan SHALL abort the scan with no done pulse; partial table contents are discarded.
REQ-026 After reset deasserts, the first start SHALL be accepted on the next rising edge.

Configuration
REQ-027 When macro TRUTH_TABLE_SCANNER_CHECK_EN is defined, the block SHALL add a checking path:
- input expected (16 bits), sampled at the accepted start and held for the scan;
- output mismatch (1 bit), valid from the done cycle until the next accepted start or reset;
- mismatch = 1 if table differs from the latched expected in any bit below 2^NVARS.
REQ-028 When TRUTH_TABLE_SCANNER_CHECK_EN is undefined, the ports expected and mismatch and all related logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-029 Bench SHALL cover: NVARS=3, function y=~b, single start pulse -> done in cycle 17, table=16'h0033, busy high in cycles 1..16.
REQ-030 Bench SHALL cover: NVARS=3, function y=b|(~a&~c) -> table=16'h00CD.
REQ-031 Bench SHALL cover: NVARS=4, function y=b|(~c&d)|(a&d) -> table=16'hFAF2, done in cycle 33, vars sequence 0..15 each held 2 cycles.
REQ-032 Bench SHALL cover: start re-pulsed in cycle 10 of a scan -> ignored; done still in cycle 33 with the correct table.
REQ-033 Bench SHALL cover: reset asserted asynchronously in cycle 20 -> outputs 0 immediately, no done pulse, and a fresh scan after release gives the correct table.
REQ-034 Bench SHALL cover, with CHECK_EN: expected=16'hFAF2 vs the REQ-031 function -> mismatch=0; expected=16'hFAF3 -> mismatch=1.

Source files
------------

// File: rtl/truth_table_scanner.sv
// Sequentially drives every input combination to an external function and captures its truth table.
// Optional checking path against an expected table is enabled by defining TRUTH_TABLE_SCANNER_CHECK_EN.
module truth_table_scanner #(
    parameter int unsigned NVARS = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [3:0]  vars,
    input  logic        y_in,
    // 'table' is a reserved word, so the captured table is exposed as truthTable
    output logic [15:0] truthTable,
    output logic        busy,
    output logic        done
`ifdef TRUTH_TABLE_SCANNER_CHECK_EN
    ,
    input  logic [15:0] expected,
    output logic        mismatch
`endif
);

    typedef enum logic [1:0] {
        Idle,
        Drive,
        Sample,
        Done
    } stateT;

    stateT            stateQ, stateD;
    logic [NVARS-1:0] indexQ, indexD;
    logic [15:0]      tableQ, tableD;
    logic [3:0]       idxWide;
    logic             acceptStart;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateQ <= Idle;
            indexQ <= '0;
            tableQ <= '0;
        end else begin
            stateQ <= stateD;
            indexQ <= indexD;
            tableQ <= tableD;
        end
    end

    // Zero-extend the index so it can address the 16-bit table and drive vars directly.
    always_comb begin
        idxWide               = '0;
        idxWide[NVARS-1:0]    = indexQ;
    end

    assign acceptStart = (stateQ == Idle) && start;

    always_comb begin
        stateD = stateQ;
        indexD = indexQ;
        tableD = tableQ;
        unique case (stateQ)
            Idle: begin
                if (start) begin
                    tableD = '0;
                    indexD = '0;
                    stateD = Drive;
                end
            end
            Drive: begin
                stateD = Sample;
            end
            Sample: begin
                tableD[idxWide] = y_in;
                if (&indexQ) begin
                    stateD = Done;
                end else begin
                    indexD = indexQ + 1'b1;
                    stateD = Drive;
                end
            end
            Done: begin
                stateD = Idle;
            end
            default: begin
                stateD = Idle;
            end
        endcase
    end

    assign busy       = (stateQ == Drive) || (stateQ == Sample);
    assign done       = (stateQ == Done);
    assign vars       = busy ? idxWide : 4'd0;
    assign truthTable = tableQ;

`ifdef TRUTH_TABLE_SCANNER_CHECK_EN
    localparam int unsigned NumRows = 1 << NVARS;
    localparam logic [15:0] RowMask = 16'((17'd1 << NumRows) - 17'd1);

    logic [15:0] expectedQ;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            expectedQ <= '0;
        end else if (acceptStart) begin
            expectedQ <= expected;
        end
    end

    // Only meaningful once the table is complete; held through IDLE until the next scan.
    assign mismatch = ((stateQ == Done) || (stateQ == Idle)) &&
                      (|((tableQ ^ expectedQ) & RowMask));
`else
    logic unusedAccept;
    assign unusedAccept = acceptStart;
`endif

endmodule
